// File: rtl/keypad_encoder_if.sv
// keypad_encoder_if
//   Key-code handshake between the keypad encoder (master) and the
//   calculator control logic (slave).
//   code    : encoded key {row[1:0], col[1:0]}
//   valid   : code holds a key the consumer has not taken yet
//   ack     : consumer accepts code (honoured only while valid is high)
//   overrun : sticky, a key was dropped because valid was still high
interface keypad_encoder_if;
  logic [3:0] code;
  logic       valid;
  logic       ack;
  logic       overrun;

  modport master (output code, output valid, output overrun, input ack);
  modport slave  (input code, input valid, input overrun, output ack);
endinterface

// File: rtl/keypad_encoder.sv
// keypad_encoder
//   Scans a 4x4 active-low key matrix one row at a time, debounces whole
//   scan frames, rejects simultaneous keys and hands the 4-bit key code to
//   the calculator through a valid/ack handshake.
//
// Ports
//   clk   : single clock
//   reset : synchronous, active-high
//   col   : column sense, active-low, asynchronous (synchronised inside)
//   row   : row drive, active-low one-cold
//   bus   : keypad_encoder_if.master (code, valid, ack, overrun)
//
// Parameters
//   SCAN_DIV       : clocks per row step (>= 4)
//   DEBOUNCE_SCANS : identical frames needed for press and for release (>= 1)
//   REPEAT_FRAMES  : auto-repeat period in frames
//
// Build option
//   KEYPAD_REPEAT_EN : when defined, a held key is re-emitted every
//                      REPEAT_FRAMES matching frames. When undefined the
//                      repeat counter still runs but never emits.
module keypad_encoder #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_FRAMES  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        col,
  output logic [3:0]        row,
  keypad_encoder_if.master  bus
);

  localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam int RW = $clog2(REPEAT_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD} state_t;

  logic [3:0]    col_meta_reg, col_sync_reg;
  logic [TW-1:0] tick_reg;
  logic [1:0]    r_reg;
  // Lows seen so far in the current frame: 0, 1, or 2 meaning "two or more".
  logic [1:0]    acc_lows_reg;
  logic [3:0]    acc_key_reg;

  state_t        state_reg, state_next;
  logic [3:0]    cand_reg, cand_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [CW-1:0] rel_reg, rel_next;
  logic [RW-1:0] rpt_reg, rpt_next;
  logic [3:0]    code_reg, code_next;
  logic          valid_reg, valid_next;
  logic          overrun_reg, overrun_next;

  logic          tick, frame_end;
  logic [1:0]    row_lows;
  logic [1:0]    row_c;
  logic [1:0]    total_lows;
  logic [3:0]    frame_key;
  logic          is_none, is_single;
  logic          emit;
  logic [3:0]    emit_key;

  assign tick      = (tick_reg == TW'(SCAN_DIV - 1));
  assign frame_end = tick && (r_reg == 2'd3);
  assign row       = ~(4'b0001 << r_reg);

  // Lows on the row being sampled; the lowest low column is kept.
  always_comb begin
    row_lows = 2'd0;
    row_c    = 2'd0;
    for (int c = 3; c >= 0; c--) begin
      if (!col_sync_reg[c]) begin
        row_c = c[1:0];
        if (row_lows != 2'd2) row_lows = row_lows + 2'd1;
      end
    end
  end

  // Merge this row's result into the frame so far (saturating at 2).
  always_comb begin
    if (acc_lows_reg == 2'd2 || row_lows == 2'd2 ||
        (acc_lows_reg == 2'd1 && row_lows == 2'd1))
      total_lows = 2'd2;
    else
      total_lows = acc_lows_reg + row_lows;
    frame_key = (acc_lows_reg == 2'd1) ? acc_key_reg : {r_reg, row_c};
  end

  assign is_none   = (total_lows == 2'd0);
  assign is_single = (total_lows == 2'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      col_meta_reg <= 4'b1111;
      col_sync_reg <= 4'b1111;
      tick_reg     <= '0;
      r_reg        <= 2'd0;
      acc_lows_reg <= 2'd0;
      acc_key_reg  <= 4'd0;
      state_reg    <= IDLE;
      cand_reg     <= 4'd0;
      cnt_reg      <= '0;
      rel_reg      <= '0;
      rpt_reg      <= '0;
      code_reg     <= 4'd0;
      valid_reg    <= 1'b0;
      overrun_reg  <= 1'b0;
    end else begin
      col_meta_reg <= col;
      col_sync_reg <= col_meta_reg;
      tick_reg     <= tick ? '0 : tick_reg + TW'(1);
      if (tick) begin
        r_reg <= r_reg + 2'd1;
        if (r_reg == 2'd3) begin
          acc_lows_reg <= 2'd0;
          acc_key_reg  <= 4'd0;
        end else begin
          acc_lows_reg <= total_lows;
          acc_key_reg  <= frame_key;
        end
      end
      state_reg   <= state_next;
      cand_reg    <= cand_next;
      cnt_reg     <= cnt_next;
      rel_reg     <= rel_next;
      rpt_reg     <= rpt_next;
      code_reg    <= code_next;
      valid_reg   <= valid_next;
      overrun_reg <= overrun_next;
    end
  end

  // Frame-level FSM plus the emit/handshake rules.
  always_comb begin
    state_next   = state_reg;
    cand_next    = cand_reg;
    cnt_next     = cnt_reg;
    rel_next     = rel_reg;
    rpt_next     = rpt_reg;
    emit         = 1'b0;
    emit_key     = cand_reg;

    if (frame_end) begin
      unique case (state_reg)
        IDLE: begin
          if (is_single) begin
            cand_next = frame_key;
            if (DEBOUNCE_SCANS == 1) begin
              emit       = 1'b1;
              emit_key   = frame_key;
              state_next = HELD;
              rel_next   = '0;
              rpt_next   = '0;
            end else begin
              state_next = DEBOUNCE;
              cnt_next   = CW'(1);
            end
          end
        end
        DEBOUNCE: begin
          if (is_single && frame_key == cand_reg) begin
            if (cnt_reg + CW'(1) == CW'(DEBOUNCE_SCANS)) begin
              emit       = 1'b1;
              state_next = HELD;
              cnt_next   = '0;
              rel_next   = '0;
              rpt_next   = '0;
            end else begin
              cnt_next = cnt_reg + CW'(1);
            end
          end else if (is_single) begin
            cand_next = frame_key;
            cnt_next  = CW'(1);
          end else begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        end
        HELD: begin
          // MULTI counts as "still pressed" so release needs clean frames.
          if (is_none) begin
            if (rel_reg + CW'(1) == CW'(DEBOUNCE_SCANS)) begin
              state_next = IDLE;
              rel_next   = '0;
            end else begin
              rel_next = rel_reg + CW'(1);
            end
          end else begin
            rel_next = '0;
          end
          if (is_single && frame_key == cand_reg) begin
            if (rpt_reg + RW'(1) == RW'(REPEAT_FRAMES)) begin
              rpt_next = '0;
`ifdef KEYPAD_REPEAT_EN
              emit     = 1'b1;
`endif
            end else begin
              rpt_next = rpt_reg + RW'(1);
            end
          end else begin
            rpt_next = '0;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    code_next    = code_reg;
    valid_next   = valid_reg;
    overrun_next = overrun_reg;
    if (valid_reg && bus.ack) valid_next = 1'b0;
    if (emit) begin
      if (!valid_reg || bus.ack) begin
        // Either the slot is free or it is being consumed this cycle.
        code_next  = emit_key;
        valid_next = 1'b1;
      end else begin
        overrun_next = 1'b1;
      end
    end
  end

  assign bus.code    = code_reg;
  assign bus.valid   = valid_reg;
  assign bus.overrun = overrun_reg;

endmodule

// File: tb/tb_keypad_encoder.sv
// tb_keypad_encoder
//   Directed bench for keypad_encoder with SCAN_DIV=4, DEBOUNCE_SCANS=2,
//   REPEAT_FRAMES=3. A small matrix model turns the pressed-key set and the
//   row drive into column levels. Expected codes are queued when a press is
//   applied and popped when the encoder raises valid.
module tb_keypad_encoder;
  localparam int SCAN_DIV = 4;
  localparam int DS       = 2;
  localparam int RF       = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [15:0] keys = 16'h0000;
  int          tests_run = 0;
  int          tests_failed = 0;
  logic [3:0]  sb[$];

  keypad_encoder_if bus ();

  keypad_encoder #(
    .SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DS), .REPEAT_FRAMES(RF)
  ) dut (
    .clk(clk), .reset(reset), .col(col), .row(row), .bus(bus)
  );

  always #5 clk = ~clk;

  // Pressed key (r,c) pulls column c low while row r is driven low.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[4*r+c] && !row[r]) col[c] = 1'b0;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Return at the negedge just after row drive wraps back to row 0,
  // i.e. right after a frame-end edge.
  task automatic align();
    int n;
    n = 0;
    while (row === 4'b1110 && n < 40) begin @(negedge clk); n++; end
    while (row !== 4'b1110 && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) begin
      tests_run++;
      tests_failed++;
      $error("FAIL align_timeout: observed row %b expected 1110 within 40 clocks", row);
    end
  endtask

  task automatic frames(input int n);
    repeat (n) align();
  endtask

  task automatic expect_emit(input string tag);
    logic [3:0] e;
    chk({tag, "_valid"}, 8'(bus.valid), 8'd1);
    chk({tag, "_sb_nonempty"}, 8'(sb.size() != 0), 8'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_code"}, 8'(bus.code), 8'(e));
    end
  endtask

  task automatic ack_pulse(input string tag);
    bus.ack = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0;
    chk({tag, "_ack_clears"}, 8'(bus.valid), 8'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk({tag, "_row"}, 8'(row), 8'h0E);
    chk({tag, "_code"}, 8'(bus.code), 8'h00);
    chk({tag, "_valid"}, 8'(bus.valid), 8'h00);
    chk({tag, "_overrun"}, 8'(bus.overrun), 8'h00);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk({tag, "_row_hold"}, 8'(row), 8'h0E);
    @(negedge clk);
    chk({tag, "_row_step"}, 8'(row), 8'h0D);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish within 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ack = 1'b0;
    reset   = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    do_reset("reset_midscan");

    bus.ack = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0;
    chk("ack_while_idle", 8'(bus.valid), 8'd0);

    // Clean press: row 2, col 1.
    align();
    keys[9] = 1'b1;
    sb.push_back(4'b1001);
    align();
    chk("press_frame1_valid", 8'(bus.valid), 8'd0);
    align();
    expect_emit("press");
    ack_pulse("press");
`ifndef KEYPAD_REPEAT_EN
    frames(3);
    chk("held_no_repeat", 8'(bus.valid), 8'd0);
`endif
    keys = 16'h0000;
    frames(3);

    // Bounce: one frame only, then two frames.
    keys[6] = 1'b1;
    align();
    keys = 16'h0000;
    frames(3);
    chk("bounce_1frame", 8'(bus.valid), 8'd0);
    keys[6] = 1'b1;
    sb.push_back(4'b0110);
    align();
    chk("bounce_2frame_early", 8'(bus.valid), 8'd0);
    align();
    expect_emit("bounce_2frame");
    keys = 16'h0000;
    ack_pulse("bounce");
    frames(3);

    // Multi-key: keys 0 and 15, then release key 0.
    keys[0]  = 1'b1;
    keys[15] = 1'b1;
    frames(3);
    chk("multi_no_valid", 8'(bus.valid), 8'd0);
    keys[0] = 1'b0;
    sb.push_back(4'b1111);
    align();
    chk("multi_release_early", 8'(bus.valid), 8'd0);
    align();
    expect_emit("multi_release");
    ack_pulse("multi");
    keys = 16'h0000;
    frames(3);

    // Overrun: key 5 left unacknowledged, then key 10 is lost.
    keys[5] = 1'b1;
    sb.push_back(4'b0101);
    frames(2);
    expect_emit("ovr_first");
    chk("ovr_first_flag", 8'(bus.overrun), 8'd0);
    keys = 16'h0000;
    frames(3);
    keys[10] = 1'b1;
    frames(2);
    chk("ovr_valid", 8'(bus.valid), 8'd1);
    chk("ovr_code_kept", 8'(bus.code), 8'h05);
    chk("ovr_flag", 8'(bus.overrun), 8'd1);
    ack_pulse("ovr");
    chk("ovr_sticky", 8'(bus.overrun), 8'd1);
    chk("ovr_code_after_ack", 8'(bus.code), 8'h05);
    keys = 16'h0000;
    do_reset("reset_after_ovr");

`ifdef KEYPAD_REPEAT_EN
    // Auto-repeat: key 3 held, every emission acknowledged.
    align();
    keys[3] = 1'b1;
    sb.push_back(4'b0011);
    frames(2);
    expect_emit("rpt_first");
    ack_pulse("rpt_first");
    for (int i = 0; i < 2; i++) begin
      sb.push_back(4'b0011);
      frames(3);
      expect_emit("rpt_again");
      ack_pulse("rpt_again");
    end
    keys = 16'h0000;
    frames(4);
    chk("rpt_stopped", 8'(bus.valid), 8'd0);
`endif

    chk("sb_drained", 8'(sb.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
